// File: rtl/intsat_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// intsat_arbiter_pkg
// Shared control-loop constants: output width derivation for the saturating
// truncation stage and its positive/negative clamp limits. Used by intsat,
// the PI loop and the intsat_arbiter wrapper.
// No ports (package).
// -----------------------------------------------------------------------------
package intsat_arbiter_pkg;

  // Default geometry of the shared saturation stage.
  localparam int DEF_N_REQ  = 4;
  localparam int DEF_IN_LEN = 64;
  localparam int DEF_LTRUNC = 32;

  // Clamp limits are built in a fixed-width word and truncated by the user
  // to OUT_LEN bits; OUT_LEN must not exceed this width.
  localparam int SAT_WORD_W = 64;

  function automatic int calc_out_len(input int in_len, input int ltrunc);
    return in_len - ltrunc;
  endfunction

  // 2^(out_len-1)-1
  function automatic logic [SAT_WORD_W-1:0] sat_pos_limit(input int out_len);
    logic [SAT_WORD_W-1:0] one;
    one = {{(SAT_WORD_W-1){1'b0}}, 1'b1};
    return (one << (out_len - 1)) - one;
  endfunction

  // -2^(out_len-1); the low out_len bits are 1 followed by zeros.
  function automatic logic [SAT_WORD_W-1:0] sat_neg_limit(input int out_len);
    return ~sat_pos_limit(out_len);
  endfunction

endpackage

// File: rtl/intsat_arbiter_intsat.sv
// -----------------------------------------------------------------------------
// intsat
// Combinational saturating truncation: removes LTRUNC bits from the top of a
// signed IN_LEN value, clamping to the OUT_LEN signed range when the dropped
// bits are not pure sign extension.
// Ports:
//   i_din     in  IN_LEN   signed input
//   o_dout    out OUT_LEN  signed narrowed/clamped result
//   o_sat_hi  out 1        input was above the positive limit
//   o_sat_lo  out 1        input was below the negative limit
// -----------------------------------------------------------------------------
module intsat
  import intsat_arbiter_pkg::*;
#(
  parameter  int IN_LEN  = DEF_IN_LEN,
  parameter  int LTRUNC  = DEF_LTRUNC,
  localparam int OUT_LEN = calc_out_len(IN_LEN, LTRUNC)
) (
  input  logic [IN_LEN-1:0]  i_din,
  output logic [OUT_LEN-1:0] o_dout,
  output logic               o_sat_hi,
  output logic               o_sat_lo
);

  localparam logic [OUT_LEN-1:0] SAT_POS = OUT_LEN'(sat_pos_limit(OUT_LEN));
  localparam logic [OUT_LEN-1:0] SAT_NEG = OUT_LEN'(sat_neg_limit(OUT_LEN));

  // The value fits when the removed bits and the new sign bit all agree.
  logic [LTRUNC:0] w_top;
  logic            w_in_range;

  assign w_top      = i_din[IN_LEN-1:OUT_LEN-1];
  assign w_in_range = (&w_top) | ~(|w_top);
  assign o_sat_hi   = ~w_in_range & ~i_din[IN_LEN-1];
  assign o_sat_lo   = ~w_in_range &  i_din[IN_LEN-1];

  always_comb begin
    o_dout = i_din[OUT_LEN-1:0];
    if (o_sat_hi) begin
      o_dout = SAT_POS;
    end else if (o_sat_lo) begin
      o_dout = SAT_NEG;
    end
  end

endmodule

// File: rtl/intsat_arbiter.sv
// -----------------------------------------------------------------------------
// intsat_arbiter
// Round-robin arbiter sharing one intsat stage between N_REQ requesters.
// A granted value is captured, narrowed with saturation, and returned on a
// per-channel valid/ready handshake.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | searching req_valid from ptr; grant + capture on first hit
//   SAT    | intsat narrows the captured value; result registered
//   RESP   | resp_valid[idx] high until resp_ready[idx]; then ptr=idx+1
//
// Ports:
//   clk         in  1              clock
//   rst_L       in  1              synchronous active-low reset
//   req_valid   in  N_REQ          channel has a value pending
//   req_data    in  N_REQ*IN_LEN   packed signed values, ch i at [i*IN_LEN +: IN_LEN]
//   req_ready   out N_REQ          one-cycle capture pulse
//   resp_valid  out N_REQ          result available for channel (one-hot or 0)
//   resp_ready  in  N_REQ          channel consumes its result
//   resp_data   out OUT_LEN        saturated result
//   resp_sat_hi out 1              result clamped to positive limit
//   resp_sat_lo out 1              result clamped to negative limit
//   busy        out 1              FSM not in IDLE
// -----------------------------------------------------------------------------
module intsat_arbiter
  import intsat_arbiter_pkg::*;
#(
  parameter  int N_REQ   = DEF_N_REQ,
  parameter  int IN_LEN  = DEF_IN_LEN,
  parameter  int LTRUNC  = DEF_LTRUNC,
  localparam int OUT_LEN = calc_out_len(IN_LEN, LTRUNC),
  localparam int IDX_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_L,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*IN_LEN-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        resp_valid,
  input  logic [N_REQ-1:0]        resp_ready,
  output logic [OUT_LEN-1:0]      resp_data,
  output logic                    resp_sat_hi,
  output logic                    resp_sat_lo,
  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SAT  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [IDX_W:0] N_REQ_W = (IDX_W+1)'(N_REQ);

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_busy;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     r_idx;
  logic [IN_LEN-1:0]    r_in;
  logic [OUT_LEN-1:0]   r_resp_data;
  logic                 r_sat_hi;
  logic                 r_sat_lo;

  logic [2*N_REQ-1:0]   w_dbl_valid;
  logic [N_REQ-1:0]     w_rot_valid;
  logic                 w_found;
  logic [IDX_W-1:0]     w_off;
  logic [IDX_W-1:0]     w_grant_idx;
  logic [IN_LEN-1:0]    w_grant_data;
  logic                 w_grant;
  logic                 w_resp_done;
  logic [OUT_LEN-1:0]   w_sat_data;
  logic                 w_sat_hi;
  logic                 w_sat_lo;

  // (a + b) mod N_REQ for operands already below N_REQ.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                 input logic [IDX_W-1:0] b);
    logic [IDX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= N_REQ_W) begin
      s = s - N_REQ_W;
    end
    return s[IDX_W-1:0];
  endfunction

  // Rotate so that bit 0 is the channel at ptr: take an N_REQ-wide window of
  // the request vector concatenated with itself.
  assign w_dbl_valid = {req_valid, req_valid};
  assign w_rot_valid = w_dbl_valid[r_ptr +: N_REQ];

  // Lowest set bit of the rotated vector; descending scan lets the lowest
  // index overwrite without an early exit.
  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot_valid[i]) begin
        w_found = 1'b1;
        w_off   = IDX_W'(i);
      end
    end
  end

  assign w_grant_idx = wrap_add(r_ptr, w_off);

  always_comb begin
    w_grant_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant_idx == IDX_W'(i)) begin
        w_grant_data = req_data[i*IN_LEN +: IN_LEN];
      end
    end
  end

  intsat #(
    .IN_LEN (IN_LEN),
    .LTRUNC (LTRUNC)
  ) u_intsat (
    .i_din    (r_in),
    .o_dout   (w_sat_data),
    .o_sat_hi (w_sat_hi),
    .o_sat_lo (w_sat_lo)
  );

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_resp_done  = 1'b0;
    req_ready    = '0;
    resp_valid   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant                = 1'b1;
          req_ready[w_grant_idx] = 1'b1;
          w_next_state           = ST_SAT;
        end
      end
      ST_SAT: begin
        w_next_state = ST_RESP;
      end
      ST_RESP: begin
        resp_valid[r_idx] = 1'b1;
        if (resp_ready[r_idx]) begin
          w_resp_done  = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    // Handshake outputs are combinational, so hold them low while reset is
    // being sampled; otherwise a requester could see a grant that never lands.
    if (!rst_L) begin
      w_grant    = 1'b0;
      req_ready  = '0;
      resp_valid = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_L) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_L) begin
      r_ptr       <= '0;
      r_idx       <= '0;
      r_in        <= '0;
      r_resp_data <= '0;
      r_sat_hi    <= 1'b0;
      r_sat_lo    <= 1'b0;
    end else begin
      if (w_grant) begin
        r_in  <= w_grant_data;
        r_idx <= w_grant_idx;
      end
      if (r_state == ST_SAT) begin
        r_resp_data <= w_sat_data;
        r_sat_hi    <= w_sat_hi;
        r_sat_lo    <= w_sat_lo;
      end
      if (w_resp_done) begin
        r_ptr <= wrap_add(r_idx, IDX_W'(1));
      end
    end
  end

  assign resp_data   = r_resp_data;
  assign resp_sat_hi = r_sat_hi;
  assign resp_sat_lo = r_sat_lo;
  assign busy        = r_busy;

endmodule

// File: doc/intsat_arbiter.md
# intsat_arbiter

Round-robin arbiter that shares one `intsat` saturating-truncation stage between `N_REQ` control-loop requesters. Each requester presents a wide signed value (e.g. a PI accumulator or product). The arbiter grants one requester at a time and narrows the value with saturation through `intsat`. It then returns the narrowed result over a per-channel valid/ready handshake. It sits between the per-channel loop arithmetic and the DAC/output registers.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `IN_LEN`, 64: signed input width.
- `LTRUNC`, 32: bits removed from the top; `OUT_LEN = IN_LEN-LTRUNC`.

Ports:
- `clk`  in  1  the only clock.
- `rst_L`  in  1  reset; synchronous, active-low.
- `req_valid`  in  N_REQ  channel i has a value pending.
- `req_data`  in  N_REQ*IN_LEN  packed signed values; channel i is at bits `[i*IN_LEN +: IN_LEN]`.
- `req_ready`  out  N_REQ  one-cycle pulse; channel i's value is captured.
- `resp_valid`  out  N_REQ  result for channel i is available; at most one bit is set.
- `resp_ready`  in  N_REQ  channel i consumes its result.
- `resp_data`  out  OUT_LEN  signed saturated result.
- `resp_sat_hi`  out  1  the result was clamped to the positive limit.
- `resp_sat_lo`  out  1  the result was clamped to the negative limit.
- `busy`  out  1  the FSM is not in IDLE.

## Operation
- FSM states are IDLE, SAT and RESP.
- IDLE:
  - Search `req_valid` starting at the round-robin pointer `ptr` and wrapping modulo N_REQ.
  - On the first set bit k: latch `req_data[k]` into `in_reg`, latch k into `idx`, pulse `req_ready[k]`, and go to SAT.
  - If no bit is set, stay in IDLE.
- SAT:
  - `intsat` combinationally narrows `in_reg`.
  - Register the result into `resp_data`. Set `resp_sat_hi` if `in_reg > 2^(OUT_LEN-1)-1`; set `resp_sat_lo` if `in_reg < -2^(OUT_LEN-1)`.
  - Go to RESP.
- RESP:
  - Assert `resp_valid[idx]`.
  - When `resp_ready[idx]` is high: set `ptr <= (idx+1) mod N_REQ` and go to IDLE.
  - `resp_ready` bits of other channels are ignored.
- Saturation rule:
  - In range: the result is `in_reg[OUT_LEN-1:0]`.
  - Above range: the result is `2^(OUT_LEN-1)-1`.
  - Below range: the result is `-2^(OUT_LEN-1)`.
- `resp_data`, `resp_sat_hi` and `resp_sat_lo` hold their value until the next SAT cycle.
- Requesters must hold `req_valid` and `req_data` until they see `req_ready`. A `req_valid` dropped before the grant is simply not serviced.
- A channel re-requesting while its own response is pending is allowed. It is not granted until after the RESP handshake completes.

## Timing
- All outputs at reset: `req_ready=0`, `resp_valid=0`, `resp_data=0`, `resp_sat_hi=0`, `resp_sat_lo=0`, `busy=0`, `ptr=0`, state IDLE.
- Grant cycle t: `req_ready[k]=1` for cycle t only.
- `resp_valid[k]` is first high at cycle t+2.
- If `resp_ready` is already high at t+2: FSM is in IDLE at t+3, and the next grant may occur at t+3.
  - Peak throughput is therefore one result per 3 cycles.
- Fairness: after serving k, the next search starts at k+1. A continuously requesting channel waits at most N_REQ-1 services.
- Reset asserted mid-operation:
  - Everything returns to its reset value on the next edge.
  - An in-flight value is dropped; its requester already saw `req_ready` and does not retry.
- `busy` equals (state != IDLE) and is registered alongside the state.

## Structure
- The `OUT_LEN` derivation and the saturation limit constants go in the shared control-loop constants header used by `intsat` and the PI loop.
- The FSM state encodings are local to this block.
- There is one sub-module: the existing `intsat`, instantiated once with `IN_LEN` and `LTRUNC` passed through.
- Pointer search is a rotate, priority-encode, un-rotate; no further sub-modules are needed.

## Test plan
Defaults N_REQ=4, IN_LEN=64, LTRUNC=32:
- Single request, ch2 `req_data=410000000`, `resp_ready` held high → `req_ready[2]` at t; `resp_valid[2]` at t+2 with `resp_data=410000000` and both sat flags 0; `ptr=3`.
- Positive overflow, ch0 `req_data=2^31` → `resp_data=2147483647`, `resp_sat_hi=1`. Also check `2^31-1` passes unclamped.
- Negative overflow, ch1 `req_data=-2^31-1` → `resp_data=-2147483648`, `resp_sat_lo=1`. Also check `-2^31` passes unclamped.
- All four channels valid continuously → grants in order 0,1,2,3,0 at 3-cycle spacing; each `req_ready` is a single-cycle pulse.
- Backpressure: hold `resp_ready[3]=0` for 5 cycles while ch0 requests → `resp_valid[3]` and `resp_data` stay stable, ch0 gets no grant, and ch0 is granted the cycle after the handshake completes.
- Reset while in RESP → all outputs 0 and state IDLE next edge; a subsequent request from ch1 is granted first, since `ptr=0` and ch0 is idle.
